// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter/mux: mode encodings and
// the select/channel-ID width helper.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    MODE_RR   = 2'b00,
    MODE_FIX  = 2'b01,
    MODE_SEL  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Width of a channel index; a two-channel arbiter still needs one bit.
  function automatic int calc_sw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Rotating first-set picker: returns the first requesting channel found when
// scanning from start upward with wrap-around.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = calc_sw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic          found,
  output logic [SW-1:0] grant
);

  logic [SW:0]   scan_sum;
  logic [SW-1:0] scan_idx;

  // Walk offsets from last to first so the smallest offset from start wins.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_sum = {1'b0, start} + (SW + 1)'(i);
      if (scan_sum >= (SW + 1)'(N)) begin
        scan_sum = scan_sum - (SW + 1)'(N);
      end
      scan_idx = scan_sum[SW-1:0];
      if (req[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage. Supports
// round-robin, fixed-priority, forced-select and hold arbitration modes.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = calc_sw(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
);

  localparam int BW = $clog2(N * W);

  mode_e         cur_mode;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic          load_en;
  logic [SW-1:0] pick_start;
  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          sel_hit;
  logic          grant_ok;
  logic [SW-1:0] grant_idx;
  logic          transfer;
  logic [BW-1:0] data_base;
  logic [W-1:0]  grant_data;

  assign cur_mode = mode_e'(mode);
  assign load_en  = !out_valid || out_ready;

  // Fixed priority is simply a round-robin scan anchored at channel 0.
  assign pick_start = (cur_mode == MODE_RR) ? ptr : '0;

  rr_arb_pick #(
    .N (N)
  ) u_pick (
    .req   (in_valid),
    .start (pick_start),
    .found (pick_found),
    .grant (pick_idx)
  );

  // Out-of-range select values simply never match any channel.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) begin
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = pick_idx;
    case (cur_mode)
      MODE_RR, MODE_FIX: grant_ok = pick_found;
      MODE_SEL: begin
        grant_ok  = sel_hit;
        grant_idx = sel;
      end
      default: grant_ok = 1'b0;
    endcase
  end

  // rst_n gates the handshake so no channel sees an accept during reset.
  assign transfer = grant_ok && load_en && rst_n;

  always_comb begin
    in_ready = '0;
    if (transfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign data_base  = BW'(grant_idx) * BW'(W);
  assign grant_data = in_data[data_base +: W];
  assign ptr_next   = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Only round-robin grants advance the rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (transfer && cur_mode == MODE_RR) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux: an 8-channel instance for the main
// scenarios and a 3-channel instance for out-of-range forced select.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic [1:0]  mode3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3;
  logic [11:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [3:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.N(8), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.N(3), .W(4)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_ready (out_ready3)
  );

  task automatic set_default_data();
    for (int i = 0; i < 8; i++) begin
      in_data[i*8 +: 8] = 8'h30 + 8'(i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
    mode3 = 2'b11; sel3 = '0; in_valid3 = '0; in_data3 = {4'hC, 4'hB, 4'hA}; out_ready3 = 1'b1;
    set_default_data();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (out_ch !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_ch: got %0d expected 0", out_ch); end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("[TB] FAIL reset_in_ready: got %h expected 00", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_ready;
    logic [2:0] exp_ch;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k <= 8; k++) begin
      exp_ready = 8'h01 << (k % 8);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %h expected %h", k, in_ready, exp_ready); end
      if (k > 0) begin
        exp_ch = 3'((k - 1) % 8);
        checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== 8'h30 + 8'(exp_ch)) begin
          errors++; $display("[TB] FAIL rr_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", k, out_valid, out_ch, out_data, exp_ch, 8'h30 + 8'(exp_ch));
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_fixed_priority();
    mode = 2'b01; in_valid = 8'b1010_0100;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++; if (in_ready !== 8'h04) begin errors++; $display("[TB] FAIL fix_grant[%0d]: got %h expected 04", j, in_ready); end
      if (j > 0) begin
        checks++; if (out_ch !== 3'd2) begin errors++; $display("[TB] FAIL fix_out_ch[%0d]: got %0d expected 2", j, out_ch); end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_forced_select();
    mode = 2'b10; sel = 3'd5; in_valid = 8'hFF;
    #1;
    for (int j = 0; j < 2; j++) begin
      checks++; if (in_ready !== 8'h20) begin errors++; $display("[TB] FAIL sel5_grant[%0d]: got %h expected 20", j, in_ready); end
      @(negedge clk); #1;
    end
    sel = 3'd3;
    #1;
    checks++; if (in_ready !== 8'h08) begin errors++; $display("[TB] FAIL sel3_grant: got %h expected 08", in_ready); end
    checks++; if (out_ch !== 3'd5) begin errors++; $display("[TB] FAIL sel5_out_ch: got %0d expected 5", out_ch); end
    @(negedge clk); #1;
    checks++; if (out_ch !== 3'd3 || out_data !== 8'h33) begin errors++; $display("[TB] FAIL sel3_out: got ch=%0d d=%h expected ch=3 d=33", out_ch, out_data); end
  endtask

  task automatic test_rr_wrap_and_hold();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h80; exp_seq[1] = 8'h01; exp_seq[2] = 8'h80;
    mode = 2'b00; in_valid = 8'b1000_0001;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++; if (in_ready !== exp_seq[j]) begin errors++; $display("[TB] FAIL rr_wrap[%0d]: got %h expected %h", j, in_ready, exp_seq[j]); end
      @(negedge clk); #1;
    end
    mode = 2'b11; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h00) begin errors++; $display("[TB] FAIL hold_no_grant: got %h expected 00", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_ch !== 3'd7) begin errors++; $display("[TB] FAIL hold_held: got v=%b ch=%0d expected v=1 ch=7", out_valid, out_ch); end
    @(negedge clk); #1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_drain: got r=%h v=%b expected r=00 v=1", in_ready, out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 8'h00) begin errors++; $display("[TB] FAIL hold_empty: got v=%b r=%h expected v=0 r=00", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    mode = 2'b10; sel = 3'd4; in_valid = 8'h10; in_data[4*8 +: 8] = 8'hA5; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h10) begin errors++; $display("[TB] FAIL bp_accept: got %h expected 10", in_ready); end
    @(negedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd4 || in_ready !== 8'h00) begin
        errors++; $display("[TB] FAIL bp_stall[%0d]: got v=%b d=%h ch=%0d r=%h expected v=1 d=a5 ch=4 r=00", j, out_valid, out_data, out_ch, in_ready);
      end
      @(negedge clk); #1;
    end
    in_valid = 8'h00; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("[TB] FAIL bp_deliver: got v=%b d=%h expected v=1 d=a5", out_valid, out_data); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_once: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    set_default_data();
    mode = 2'b00; in_valid = 8'h04; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h04) begin errors++; $display("[TB] FAIL pre_rst_grant: got %h expected 04", in_ready); end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
      errors++; $display("[TB] FAIL rst_async_clear: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0", out_valid, out_data, out_ch);
    end
    checks++; if (in_ready !== 8'h00) begin errors++; $display("[TB] FAIL rst_in_ready: got %h expected 00", in_ready); end
    @(negedge clk);
    in_valid = 8'h14;
    #1;
    checks++; if (in_ready !== 8'h00) begin errors++; $display("[TB] FAIL rst_in_ready2: got %h expected 00", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h04) begin errors++; $display("[TB] FAIL post_rst_grant: got %h expected 04", in_ready); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 8'h32) begin
      errors++; $display("[TB] FAIL post_rst_out: got v=%b ch=%0d d=%h expected v=1 ch=2 d=32", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_small_n();
    mode3 = 2'b10; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("[TB] FAIL n3_sel_oob: got %b expected 000", in_ready3); end
    @(negedge clk); #1;
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("[TB] FAIL n3_no_beat: got %b expected 0", out_valid3); end
    sel3 = 2'd2;
    #1;
    checks++; if (in_ready3 !== 3'b100) begin errors++; $display("[TB] FAIL n3_sel2: got %b expected 100", in_ready3); end
    @(negedge clk); #1;
    checks++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 4'hC) begin
      errors++; $display("[TB] FAIL n3_out: got v=%b ch=%0d d=%h expected v=1 ch=2 d=c", out_valid3, out_ch3, out_data3);
    end
  endtask

  initial begin
    $display("[TB] starting rr_arb_mux directed tests");
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_forced_select();
    test_rr_wrap_and_hold();
    test_backpressure();
    test_reset_midstream();
    test_small_n();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N, default 8: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..64.
REQ-003 Local constant SW = max(1, clog2(N)): width of the select and channel-ID fields.
REQ-004 clk  in  1  sole clock; all state is updated on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 mode  in  2  arbitration mode: 00 round-robin, 01 fixed priority, 10 forced select, 11 hold (no grants).
REQ-007 sel  in  SW  channel index used in forced-select mode.
REQ-008 in_valid  in  N  per-channel request; bit i belongs to channel i.
REQ-009 in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-010 in_ready  out  N  per-channel accept; at most one bit is high per cycle.
REQ-011 out_valid  out  1  output register holds a beat.
REQ-012 out_data  out  W  registered data of the held beat.
REQ-013 out_ch  out  SW  index of the channel that supplied the held beat.
REQ-014 out_ready  in  1  downstream accept.

Function
REQ-015 load_en = !out_valid || out_ready; no channel shall be granted when load_en is 0.
REQ-016 Transfer on channel i occurs when in_valid[i] && in_ready[i]; transfer on the output occurs when out_valid && out_ready.
REQ-017 in_ready[i] is 1 only when load_en is 1, channel i is the grant, and in_valid[i] is 1; it is combinational from the inputs and state.
REQ-018 Round-robin: the grant is the first valid channel scanning ptr, ptr+1, ..., ptr+N-1 mod N.
REQ-019 Round-robin: after a grant to g, ptr becomes (g+1) mod N; ptr is unchanged in cycles with no grant.
REQ-020 Fixed priority: the grant is the lowest-index valid channel; ptr is unchanged.
REQ-021 Forced select: only channel sel may be granted; a sel value >= N grants nothing; ptr is unchanged.
REQ-022 Hold mode (11): no channel is granted; the output may still drain.
REQ-023 Latency: a beat accepted at edge k appears on out_valid, out_data and out_ch after edge k, i.e. in cycle k+1.
REQ-024 Throughput: with out_ready held at 1, one beat per cycle shall be sustained.
REQ-025 While out_valid && !out_ready, out_data and out_ch shall stay stable and out_valid shall stay 1.
REQ-026 On an output transfer with no new grant, out_valid falls to 0 at the next edge.
REQ-027 On an output transfer with a new grant in the same cycle, the output register reloads with no bubble.
REQ-028 A mode or sel change takes effect in the same cycle's arbitration.
REQ-029 No beat shall be dropped or duplicated under any mode sequence.

Reset
REQ-030 While rst_n is 0, out_valid=0, out_data=0, out_ch=0 and ptr=0, applied asynchronously.
REQ-031 While rst_n is 0, in_ready shall be all 0 regardless of other inputs.
REQ-032 A beat held at reset assertion is discarded; the first grant after release, in round-robin mode, starts the scan at channel 0.

Structure
REQ-033 A shared package rr_arb_pkg shall hold the mode encodings (MODE_RR, MODE_FIX, MODE_SEL, MODE_HOLD) and the SW width function.
REQ-034 A combinational sub-module rr_arb_pick (inputs: request vector, start index; outputs: found, grant index) shall be used for both round-robin and fixed-priority picks, with start index 0 for fixed priority.
REQ-035 The datapath shall use an indexed part-select on the grant index, with no per-channel case statement.

Verification
REQ-036 Reset release, mode=00, in_valid=8'hFF, out_ready=1 -> grants 0,1,...,7,0 on consecutive cycles; out_ch follows one cycle later.
REQ-037 mode=01, in_valid=8'b1010_0100 -> only ch2 is granted on every cycle; ptr is unchanged.
REQ-038 mode=10, sel=5, in_valid=8'hFF, then sel=3 -> ch5 is granted, then ch3 from the cycle sel changes.
REQ-039 Beat from ch4 (data 8'hA5) with out_ready=0 for 3 cycles -> out_data=8'hA5 and out_ch=4 are stable, in_ready=0 throughout, and the beat is delivered once when out_ready rises.
REQ-040 Round-robin with in_valid=8'b1000_0001 and ptr=1 -> grant ch7, then ch0, then ch7; mode switched to 11 mid-stream -> no further grants while the held beat still drains.
REQ-041 rst_n pulsed low while out_valid=1 -> outputs clear immediately; after release the first round-robin grant goes to the lowest valid channel; also repeat with N=3 and sel=3 -> no grant.
